apb_spi_master: RTL

APB slave that owns the SPI master's register file and its 8-bit shift engine. It consumes APB transfers carried on the `apb_intf` signal set and drives a single-slave SPI bus. Software writes a byte to TXDATA, polls STATUS, then reads the received byte from RXDATA.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_shift_engine.sv | 129 ++++++++++++
 rtl/apb_spi_master.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the APB SPI master: register addresses, CTRL and
// STATUS bit positions, and the shift-engine state encoding.
package spi_pkg;

  // Register byte addresses (word aligned)
  localparam int unsigned ADDR_CTRL = 32'h0;
  localparam int unsigned ADDR_TX   = 32'h4;
  localparam int unsigned ADDR_RX   = 32'h8;
  localparam int unsigned ADDR_STAT = 32'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_CPOL    = 1;
  localparam int unsigned CTRL_CPHA    = 2;
  localparam int unsigned CTRL_LOOP    = 3;
  localparam int unsigned CTRL_DIV_LSB = 8;
  localparam int unsigned CTRL_DIV_MSB = 15;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI shift engine: FSM, half-period divider, SCLK edge counter and the
// transmit/receive shift registers for one 8-bit MSB-first transfer.
//
// Optional build macro: SPI_LOOPBACK_EN adds the 'loop' input, which makes
// the engine sample its own MOSI instead of the MISO pin.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, tx_byte  start pulse (honoured in IDLE) and byte to send
//   cpol, cpha      SPI mode; clkdiv sets half-period H = clkdiv + 1
//   miso            serial input
//   sclk, mosi      serial clock and data out
//   cs_n, busy      chip select and transfer-in-progress flag
//   done, rx_byte   one-cycle pulse on the HOLD->IDLE edge, received byte
module spi_shift_engine
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       cpol,
  input  logic       cpha,
`ifdef SPI_LOOPBACK_EN
  input  logic       loop,
`endif
  input  logic [7:0] clkdiv,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  spi_state_e state_q, state_d;
  logic [8:0] cnt_q;
  logic [3:0] edge_q;
  logic       phase_q;
  logic [7:0] tx_sr_q;
  logic [7:0] rx_sr_q;

  logic tick, shift_tick, lead_edge, sample_edge, drive_edge, sin;

  // The divider is preloaded with H on start, so SETUP lasts H+1 cycles
  // (CS_N asserts one cycle before the first half-period starts) and the
  // whole transfer spans 18*H + 1 cycles.
  assign tick       = (cnt_q == 9'd0);
  assign shift_tick = (state_q == SHIFT) && tick;
  // edge_q counts SCLK edges already made; an even count means the next
  // edge is a leading (odd-numbered) one.
  assign lead_edge   = ~edge_q[0];
  assign sample_edge = cpha ? ~lead_edge : lead_edge;
  // With CPHA=1 bit 7 is already on MOSI at the first leading edge, so the
  // first shift happens on the second leading edge.
  assign drive_edge  = cpha ? (lead_edge && (edge_q != 4'd0)) : ~lead_edge;

`ifdef SPI_LOOPBACK_EN
  assign sin = loop ? tx_sr_q[7] : miso;
`else
  assign sin = miso;
`endif

  assign rx_byte = rx_sr_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && (edge_q == 4'd15)) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cs_n = 1'b1;
    busy = 1'b0;
    mosi = 1'b0;
    done = 1'b0;
    sclk = cpol ^ phase_q;
    if (state_q != IDLE) begin
      cs_n = 1'b0;
      busy = 1'b1;
      mosi = tx_sr_q[7];
    end
    if ((state_q == HOLD) && tick) done = 1'b1;
  end

  // Divider, edge counter and SCLK phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      edge_q  <= '0;
      phase_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cnt_q   <= {1'b0, clkdiv} + 9'd1;
        edge_q  <= '0;
        phase_q <= 1'b0;
      end
    end else begin
      cnt_q <= tick ? {1'b0, clkdiv} : cnt_q - 9'd1;
      if (shift_tick) begin
        phase_q <= ~phase_q;
        edge_q  <= edge_q + 4'd1;
      end
    end
  end

  // Shift registers carry data only; MOSI is gated by busy so they need
  // no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start)   tx_sr_q <= tx_byte;
    else if (shift_tick && drive_edge) tx_sr_q <= {tx_sr_q[6:0], 1'b0};
    if (shift_tick && sample_edge)     rx_sr_q <= {rx_sr_q[6:0], sin};
  end

endmodule

// File: rtl/apb_spi_master.sv
// APB slave holding the SPI master register file (CTRL, TXDATA, RXDATA,
// STATUS) in front of a single-slave SPI shift engine.
//
// Optional build macro: SPI_LOOPBACK_EN makes CTRL[3] a RW LOOP bit that
// routes MOSI back into the receiver; without it CTRL[3] reads 0.
//
// Ports:
//   PCLK, PRESETn            clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA            APB request
//   PRDATA, PREADY, PSLVERR  APB response (zero wait states)
//   SPI_SCLK, SPI_MOSI,
//   SPI_MISO, SPI_CS_N       SPI bus
module apb_spi_master
  import spi_pkg::*;
#(
  parameter int unsigned AWIDTH     = 4,
  parameter int unsigned DWIDTH     = 32,
  parameter logic [7:0]  DEF_CLKDIV = 8'd3
)(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AWIDTH-1:0] PADDR,
  input  logic [DWIDTH-1:0] PWDATA,
  output logic [DWIDTH-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              SPI_SCLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_CS_N
);

  logic       en_q, cpol_q, cpha_q, loop_q;
  logic [7:0] clkdiv_q;
  logic [7:0] rxdata_q;
  logic       done_q;

  logic       aligned, sel_ctrl, sel_tx, sel_rx, sel_stat;
  logic       access, wr_acc, rd_acc;
  logic       busy, eng_done, tx_start, ctrl_wr, done_clr;
  logic [7:0] eng_rx;
  logic       unused_pwdata;

  assign unused_pwdata = ^PWDATA[DWIDTH-1:16];

  assign aligned  = (PADDR[1:0] == 2'b00);
  assign sel_ctrl = aligned && (PADDR == AWIDTH'(ADDR_CTRL));
  assign sel_tx   = aligned && (PADDR == AWIDTH'(ADDR_TX));
  assign sel_rx   = aligned && (PADDR == AWIDTH'(ADDR_RX));
  assign sel_stat = aligned && (PADDR == AWIDTH'(ADDR_STAT));

  assign access = PSEL & PENABLE;
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;

  assign tx_start = wr_acc & sel_tx & en_q & ~busy;
  assign ctrl_wr  = wr_acc & sel_ctrl & ~busy;
  assign done_clr = (rd_acc & sel_rx) | (wr_acc & sel_stat & PWDATA[STAT_DONE]);

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~aligned |
                   (PWRITE & ((sel_ctrl & busy) |
                              (sel_tx & (busy | ~en_q)) |
                              sel_rx)));

`ifndef SPI_LOOPBACK_EN
  assign loop_q = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      en_q     <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      clkdiv_q <= DEF_CLKDIV;
`ifdef SPI_LOOPBACK_EN
      loop_q   <= 1'b0;
`endif
      rxdata_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q     <= PWDATA[CTRL_EN];
        cpol_q   <= PWDATA[CTRL_CPOL];
        cpha_q   <= PWDATA[CTRL_CPHA];
        clkdiv_q <= PWDATA[CTRL_DIV_MSB:CTRL_DIV_LSB];
`ifdef SPI_LOOPBACK_EN
        loop_q   <= PWDATA[CTRL_LOOP];
`endif
      end
      if (eng_done) rxdata_q <= eng_rx;
      // A completing transfer wins over a same-cycle clear.
      if (eng_done)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      if (sel_ctrl) begin
        PRDATA[CTRL_EN]                   = en_q;
        PRDATA[CTRL_CPOL]                 = cpol_q;
        PRDATA[CTRL_CPHA]                 = cpha_q;
        PRDATA[CTRL_LOOP]                 = loop_q;
        PRDATA[CTRL_DIV_MSB:CTRL_DIV_LSB] = clkdiv_q;
      end else if (sel_rx) begin
        PRDATA[7:0] = rxdata_q;
      end else if (sel_stat) begin
        PRDATA[STAT_BUSY] = busy;
        PRDATA[STAT_DONE] = done_q;
      end
    end
  end

  spi_shift_engine u_engine (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .start   (tx_start),
    .tx_byte (PWDATA[7:0]),
    .cpol    (cpol_q),
    .cpha    (cpha_q),
`ifdef SPI_LOOPBACK_EN
    .loop    (loop_q),
`endif
    .clkdiv  (clkdiv_q),
    .miso    (SPI_MISO),
    .sclk    (SPI_SCLK),
    .mosi    (SPI_MOSI),
    .cs_n    (SPI_CS_N),
    .busy    (busy),
    .done    (eng_done),
    .rx_byte (eng_rx)
  );

endmodule
